// File: rtl/time_dmr_end_checker.sv
// Receive side of the time-redundant DMR path: compares back-to-back copies,
// forwards one verified copy, flags faults and requests retries.
// Ports: clk_i/rst_i (sync, active-high), enable_i selects duplicated/bypass,
//   data_i/id_i/valid_i/ready_o upstream, data_o/id_o/valid_o/ready_i
//   downstream, fault_o pulse, retry_valid_o pulse with held retry_id_o.
// Optional: define TIME_DMR_END_TIMEOUT_EN for the HOLD partner timeout.
module time_dmr_end_checker #(
    parameter type         DataType      = logic,
    parameter int unsigned IDSize        = 2,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  DataType           data_i,
    input  logic [IDSize-1:0] id_i,
    input  logic              valid_i,
    output logic              ready_o,
    output DataType           data_o,
    output logic [IDSize-1:0] id_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              fault_o,
    output logic              retry_valid_o,
    output logic [IDSize-1:0] retry_id_o
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        OUT
    } state_e;

    state_e            state_q, state_d;
    DataType           data_q, data_d;
    logic [IDSize-1:0] id_q, id_d;
    logic [IDSize-1:0] retry_id_q, retry_id_d;
    logic              fault_q, fault_d;
    logic              retry_valid_q, retry_valid_d;

    logic parity_bad;
    logic id_match;
    logic data_match;
    logic timeout_hit;

    // Even parity over the whole ID, parity bit included.
    assign parity_bad = ^id_i;
    assign id_match   = (id_i == id_q);
    assign data_match = (data_i == data_q);

`ifdef TIME_DMR_END_TIMEOUT_EN
    localparam logic [7:0] TmoLimit =
        (TimeoutCycles > 255) ? 8'd255 : 8'(TimeoutCycles);

    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    // Counts idle HOLD cycles; restarts on HOLD entry and any new beat.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q != HOLD || valid_i) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != 8'hFF) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_hit = (state_q == HOLD) && (tmo_cnt_q == TmoLimit);
`else
    logic unused_timeout;
    assign unused_timeout = ^TimeoutCycles;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        id_d          = id_q;
        retry_id_d    = retry_id_q;
        fault_d       = 1'b0;
        retry_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (parity_bad) begin
                        fault_d = 1'b1;
                    end else begin
                        data_d  = data_i;
                        id_d    = id_i;
                        state_d = enable_i ? HOLD : OUT;
                    end
                end
            end
            HOLD: begin
                if (valid_i) begin
                    // Every non-matching outcome retries the buffered ID.
                    if (parity_bad) begin
                        fault_d       = 1'b1;
                        retry_valid_d = 1'b1;
                        retry_id_d    = id_q;
                        state_d       = IDLE;
                    end else if (id_match && data_match) begin
                        state_d = OUT;
                    end else if (id_match) begin
                        fault_d       = 1'b1;
                        retry_valid_d = 1'b1;
                        retry_id_d    = id_q;
                        state_d       = IDLE;
                    end else begin
                        // Partner lost: new element becomes the first copy.
                        fault_d       = 1'b1;
                        retry_valid_d = 1'b1;
                        retry_id_d    = id_q;
                        data_d        = data_i;
                        id_d          = id_i;
                    end
                end else if (timeout_hit) begin
                    fault_d       = 1'b1;
                    retry_valid_d = 1'b1;
                    retry_id_d    = id_q;
                    state_d       = IDLE;
                end
            end
            OUT: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            data_q        <= '0;
            id_q          <= '0;
            retry_id_q    <= '0;
            fault_q       <= 1'b0;
            retry_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            id_q          <= id_d;
            retry_id_q    <= retry_id_d;
            fault_q       <= fault_d;
            retry_valid_q <= retry_valid_d;
        end
    end

    assign ready_o       = (state_q != OUT);
    assign valid_o       = (state_q == OUT);
    assign data_o        = data_q;
    assign id_o          = id_q;
    assign fault_o       = fault_q;
    assign retry_valid_o = retry_valid_q;
    assign retry_id_o    = retry_id_q;

endmodule
